topological_sort_stream: RTL and testbench
==========================================

Name: topological_sort_stream

Overview:
- Complete Kahn's-algorithm topological sorter for the day-11 graph solver.
- Accepts a directed edge stream from the input decoder and builds in-degree and adjacency-list storage on-chip.
- After `decoding_done`, emits every node in topological order on a ready/valid output stream.
- Flags cycles, edge-table overflow and the final node count.

Parameters:
- MAX_NODES, 1024: node-id space; ids 0..MAX_NODES-1.
- MAX_EDGES, 2048: edge-table capacity.
- NODE_WIDTH, $clog2(MAX_NODES): node-id width.
- EDGE_WIDTH, $clog2(MAX_EDGES): edge-index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- load_ready  out  1  high when edges/done are accepted (LOAD state).
- edge_valid  in  1  edge src_node->dst_node presented; sampled only when load_ready.
- src_node  in  NODE_WIDTH  edge source.
- dst_node  in  NODE_WIDTH  edge destination.
- decoding_done  in  1  single-cycle pulse, end of edge list; sampled only when load_ready.
- out_valid  out  1  sorted_node valid.
- out_ready  in  1  consumer accepts sorted_node.
- sorted_node  out  NODE_WIDTH  next node in topological order.
- sort_done  out  1  sticky; sort finished, all emissions complete.
- cycle_detected  out  1  sticky; emitted count < active node count at finish.
- edge_overflow  out  1  sticky; edge dropped because the table was full.
- node_count  out  NODE_WIDTH+1  number of active nodes (touched by ≥1 edge); valid with sort_done.

Behaviour:
- Reset values:
  - All outputs 0 / deasserted.
  - FSM enters CLEAR.
  - Edge count, queue pointers and counters are zeroed.
- Storage:
  - in_degree[MAX_NODES] (NODE_WIDTH+1 bits).
  - head[MAX_NODES] (EDGE_WIDTH+1 bits, MSB set = null).
  - active[MAX_NODES] bit.
  - edge_dst[MAX_EDGES] and edge_next[MAX_EDGES].
  - Circular queue q[MAX_NODES].
  - No RAM has async reset.
- CLEAR:
  - Walks index 0..MAX_NODES-1, one entry per cycle.
  - Writes in_degree=0, head=null, active=0.
  - Takes MAX_NODES cycles, then goes to LOAD.
  - load_ready is low throughout.
  - Reset asserted mid-operation in any state returns to CLEAR.
- LOAD:
  - load_ready=1.
  - Edge accepted while edge count < MAX_EDGES:
    - edge_dst[e]=dst_node, edge_next[e]=head[src].
    - head[src]=e; e increments.
    - active[src]=active[dst]=1.
    - in_degree[dst] is incremented through a 2-stage read-modify-write.
  - Back-to-back edges to the same dst must forward the pending increment. Degree must be exact for any stream, one edge per cycle.
  - Edge accepted when edge count == MAX_EDGES: dropped, edge_overflow set, no table modified.
  - decoding_done: enters SWEEP after the RMW pipe drains (≤2 cycles). edge_valid in the same cycle as decoding_done is still taken.
- SWEEP:
  - Scans ids 0..MAX_NODES-1, one per cycle.
  - Counts active nodes into node_count.
  - Pushes active ids with in_degree==0 to the queue in ascending id order.
  - Then enters POP.
- POP:
  - Queue empty → FINISH.
  - Otherwise dequeue node n and present it: out_valid=1, sorted_node=n.
  - Held stable until out_ready; the transfer happens on the out_valid&&out_ready cycle.
  - Then edge pointer p=head[n], enter WALK.
- WALK:
  - While p not null: dst=edge_dst[p], in_degree[dst]-=1, push dst if the result is 0, p=edge_next[p].
  - ≤2 cycles per edge; the RMW hazard is handled as in LOAD.
  - p null → POP.
  - Queue can never exceed MAX_NODES entries, so no full check is needed. Pointers wrap modulo MAX_NODES.
- FINISH:
  - sort_done=1.
  - cycle_detected = (emitted != node_count).
  - FSM stays in FINISH until reset.
- Ordering:
  - Nodes sharing a level appear in queue order: sweep order first, then order of decrement-to-zero.
  - Outgoing edges are walked in reverse insertion order (LIFO list).
- Self-loop src==dst: the node never reaches zero in-degree, so cycle_detected is set.
- Duplicate edges: counted twice and decremented twice; no deduplication.
- Empty graph (decoding_done with no edges): node_count=0, no outputs, sort_done with cycle_detected=0.

Test Plan:
- Chain 0→1, 1→2, 2→3, then done, out_ready=1 → sorted 0,1,2,3; node_count=4; sort_done=1; cycle_detected=0.
- Diamond 5→7, 5→9, 7→3, 9→3, out_ready toggled 1/0 each cycle → 5 first, 3 last, {7,9} between; each value held stable while stalled; exactly 4 transfers.
- Cycle 1→2, 2→1, 0→4 → outputs 0,4 only; node_count=4; cycle_detected=1.
- 3 back-to-back edges 0→8 plus 1→8, 2→8 on consecutive cycles → 8 is emitted only after 0,1,2 (in-degree 5 exact); emission count=4.
- MAX_EDGES=4 variant, 6 edges i→i+1 for i=0..5 → edge_overflow=1; output 0,1,2,3,4 then sort_done, with node_count=5.
- rst_n asserted during WALK, then a new 2-edge graph 10→11, 11→12 → load_ready low for MAX_NODES cycles; output 10,11,12 only; no stale nodes.

Source files
------------

// File: rtl/topological_sort_stream.sv
// Streaming Kahn's-algorithm topological sorter: builds in-degree and adjacency
// lists from an edge stream, then emits every active node in topological order.
module topological_sort_stream #(
    parameter int unsigned MAX_NODES  = 1024,
    parameter int unsigned MAX_EDGES  = 2048,
    parameter int unsigned NODE_WIDTH = $clog2(MAX_NODES),
    parameter int unsigned EDGE_WIDTH = $clog2(MAX_EDGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  load_ready,
    input  logic                  edge_valid,
    input  logic [NODE_WIDTH-1:0] src_node,
    input  logic [NODE_WIDTH-1:0] dst_node,
    input  logic                  decoding_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NODE_WIDTH-1:0] sorted_node,
    output logic                  sort_done,
    output logic                  cycle_detected,
    output logic                  edge_overflow,
    output logic [NODE_WIDTH:0]   node_count
);

    localparam int unsigned DEG_W = NODE_WIDTH + 1;
    localparam int unsigned PTR_W = EDGE_WIDTH + 1;
    localparam int unsigned CNT_W = NODE_WIDTH + 1;
    localparam logic [NODE_WIDTH-1:0] LAST_ID   = NODE_WIDTH'(MAX_NODES - 1);
    localparam logic [PTR_W-1:0]      EDGE_CAP  = PTR_W'(MAX_EDGES);
    localparam logic [PTR_W-1:0]      NULL_PTR  = {1'b1, {EDGE_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_CLEAR,
        S_LOAD,
        S_DRAIN,
        S_SWEEP,
        S_POP,
        S_EMIT,
        S_WALK,
        S_FINISH
    } state_t;

    state_t state, next_state;

    // Graph storage (no reset; CLEAR initialises the per-node tables)
    logic [DEG_W-1:0]      in_degree [MAX_NODES];
    logic [PTR_W-1:0]      head      [MAX_NODES];
    logic                  active    [MAX_NODES];
    logic [NODE_WIDTH-1:0] edge_dst  [MAX_EDGES];
    logic [PTR_W-1:0]      edge_next [MAX_EDGES];
    logic [NODE_WIDTH-1:0] q_mem     [MAX_NODES];

    // Control registers
    logic [NODE_WIDTH-1:0] idx;
    logic [PTR_W-1:0]      edge_cnt;
    logic [NODE_WIDTH-1:0] q_wr;
    logic [NODE_WIDTH-1:0] q_rd;
    logic [CNT_W-1:0]      q_cnt;
    logic [CNT_W-1:0]      emitted;
    logic [PTR_W-1:0]      walk_p;

    // In-degree read-modify-write pipeline
    logic                  s1_v;
    logic                  s1_dec;
    logic [NODE_WIDTH-1:0] s1_dst;
    logic                  s2_v;
    logic                  s2_push;
    logic [NODE_WIDTH-1:0] s2_dst;
    logic [DEG_W-1:0]      s2_val;

    logic                  idx_last;
    logic                  store;
    logic                  drop;
    logic                  walk_step;
    logic                  q_empty;
    logic                  pop;
    logic                  xfer;
    logic                  sweep_push;
    logic                  push;
    logic [NODE_WIDTH-1:0] push_node;
    logic [DEG_W-1:0]      s1_base;
    logic [DEG_W-1:0]      s1_new;

    function automatic logic [NODE_WIDTH-1:0] q_inc(input logic [NODE_WIDTH-1:0] p);
        return (p == LAST_ID) ? '0 : p + NODE_WIDTH'(1);
    endfunction

    // Handshake and pipeline decode
    always_comb begin
        idx_last   = (idx == LAST_ID);
        store      = (state == S_LOAD) && edge_valid && (edge_cnt < EDGE_CAP);
        drop       = (state == S_LOAD) && edge_valid && (edge_cnt >= EDGE_CAP);
        walk_step  = (state == S_WALK) && !walk_p[PTR_W-1];
        q_empty    = (q_cnt == '0);
        pop        = (state == S_POP) && !q_empty;
        xfer       = (state == S_EMIT) && out_ready;
        sweep_push = (state == S_SWEEP) && active[idx] && (in_degree[idx] == '0);
        push       = sweep_push || (s2_v && s2_push);
        push_node  = sweep_push ? idx : s2_dst;
        // Forward the in-flight write when consecutive updates hit the same node
        s1_base    = (s2_v && (s2_dst == s1_dst)) ? s2_val : in_degree[s1_dst];
        s1_new     = s1_dec ? s1_base - DEG_W'(1) : s1_base + DEG_W'(1);
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_CLEAR:  if (idx_last) next_state = S_LOAD;
            S_LOAD:   if (decoding_done) next_state = S_DRAIN;
            S_DRAIN:  if (!s1_v) next_state = S_SWEEP;
            S_SWEEP:  if (idx_last) next_state = S_POP;
            S_POP:    next_state = q_empty ? S_FINISH : S_EMIT;
            S_EMIT:   if (out_ready) next_state = S_WALK;
            S_WALK:   if (walk_p[PTR_W-1] && !s1_v) next_state = S_POP;
            S_FINISH: next_state = S_FINISH;
            default:  next_state = S_CLEAR;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_CLEAR;
        else        state <= next_state;
    end

    // Counters, pointers, pipeline and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx            <= '0;
            edge_cnt       <= '0;
            q_wr           <= '0;
            q_rd           <= '0;
            q_cnt          <= '0;
            emitted        <= '0;
            walk_p         <= NULL_PTR;
            s1_v           <= 1'b0;
            s1_dec         <= 1'b0;
            s1_dst         <= '0;
            s2_v           <= 1'b0;
            s2_push        <= 1'b0;
            s2_dst         <= '0;
            s2_val         <= '0;
            load_ready     <= 1'b0;
            out_valid      <= 1'b0;
            sorted_node    <= '0;
            sort_done      <= 1'b0;
            cycle_detected <= 1'b0;
            edge_overflow  <= 1'b0;
            node_count     <= '0;
        end else begin
            if (state == S_CLEAR || state == S_SWEEP)
                idx <= idx_last ? '0 : idx + NODE_WIDTH'(1);
            if (store)
                edge_cnt <= edge_cnt + PTR_W'(1);
            if (drop)
                edge_overflow <= 1'b1;

            s1_v    <= store || walk_step;
            s1_dec  <= walk_step;
            s1_dst  <= walk_step ? edge_dst[walk_p[EDGE_WIDTH-1:0]] : dst_node;
            s2_v    <= s1_v;
            s2_dst  <= s1_dst;
            s2_val  <= s1_new;
            s2_push <= s1_v && s1_dec && (s1_new == '0);

            if (xfer)
                walk_p <= head[sorted_node];
            else if (walk_step)
                walk_p <= edge_next[walk_p[EDGE_WIDTH-1:0]];

            if (push) q_wr <= q_inc(q_wr);
            if (pop)  q_rd <= q_inc(q_rd);
            q_cnt <= q_cnt + CNT_W'(push) - CNT_W'(pop);

            if (state == S_SWEEP && active[idx])
                node_count <= node_count + CNT_W'(1);
            if (xfer)
                emitted <= emitted + CNT_W'(1);

            if (pop) begin
                out_valid   <= 1'b1;
                sorted_node <= q_mem[q_rd];
            end else if (xfer) begin
                out_valid   <= 1'b0;
            end

            load_ready <= (next_state == S_LOAD);
            sort_done  <= (next_state == S_FINISH);
            if (state == S_POP && q_empty)
                cycle_detected <= (emitted != node_count);
        end
    end

    // In-degree table: cleared in CLEAR, written by the RMW pipeline's second stage
    always_ff @(posedge clk) begin
        if (state == S_CLEAR)
            in_degree[idx] <= '0;
        else if (s2_v)
            in_degree[s2_dst] <= s2_val;
    end

    // Adjacency list heads: null in CLEAR, new edge prepended on store
    always_ff @(posedge clk) begin
        if (state == S_CLEAR)
            head[idx] <= NULL_PTR;
        else if (store)
            head[src_node] <= {1'b0, edge_cnt[EDGE_WIDTH-1:0]};
    end

    // Active-node flags
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            active[idx] <= 1'b0;
        end else if (store) begin
            active[src_node] <= 1'b1;
            active[dst_node] <= 1'b1;
        end
    end

    // Edge table: destination and link to the previous head of the source list
    always_ff @(posedge clk) begin
        if (store) begin
            edge_dst[edge_cnt[EDGE_WIDTH-1:0]]  <= dst_node;
            edge_next[edge_cnt[EDGE_WIDTH-1:0]] <= head[src_node];
        end
    end

    // Ready queue storage
    always_ff @(posedge clk) begin
        if (push)
            q_mem[q_wr] <= push_node;
    end

endmodule

// File: tb/tb_topological_sort_stream.sv
// Bench for topological_sort_stream: fixed vector table, hand sequences and
// random graphs checked against a Kahn's-algorithm reference model.
module tb_topological_sort_stream;

    localparam int unsigned MAX_NODES = 1024;
    localparam int unsigned MAX_EDGES = 2048;
    localparam int unsigned NW        = 10;
    localparam int unsigned SN        = 16;
    localparam int unsigned SE        = 4;
    localparam int unsigned SNW       = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          load_ready, edge_valid, decoding_done, out_valid, out_ready;
    logic [NW-1:0] src_node, dst_node, sorted_node;
    logic          sort_done, cycle_detected, edge_overflow;
    logic [NW:0]   node_count;

    logic           s_load_ready, s_edge_valid, s_decoding_done, s_out_valid, s_out_ready;
    logic [SNW-1:0] s_src_node, s_dst_node, s_sorted_node;
    logic           s_sort_done, s_cycle_detected, s_edge_overflow;
    logic [SNW:0]   s_node_count;

    topological_sort_stream u_dut (
        .clk(clk), .rst_n(rst_n), .load_ready(load_ready), .edge_valid(edge_valid),
        .src_node(src_node), .dst_node(dst_node), .decoding_done(decoding_done),
        .out_valid(out_valid), .out_ready(out_ready), .sorted_node(sorted_node),
        .sort_done(sort_done), .cycle_detected(cycle_detected),
        .edge_overflow(edge_overflow), .node_count(node_count)
    );

    topological_sort_stream #(.MAX_NODES(SN), .MAX_EDGES(SE)) u_small (
        .clk(clk), .rst_n(rst_n), .load_ready(s_load_ready), .edge_valid(s_edge_valid),
        .src_node(s_src_node), .dst_node(s_dst_node), .decoding_done(s_decoding_done),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .sorted_node(s_sorted_node),
        .sort_done(s_sort_done), .cycle_detected(s_cycle_detected),
        .edge_overflow(s_edge_overflow), .node_count(s_node_count)
    );

    typedef struct {
        int ne;
        int src[6];
        int dst[6];
        int nout;
        int outv[6];
        int nc;
        int cyc;
    } vec_t;

    vec_t tbl[7];
    int   passed = 0;
    int   total  = 0;
    int   g_src[$];
    int   g_dst[$];
    int   exp_q[$];
    int   got_q[$];
    int   exp_nc;
    int   exp_cyc;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Reference: Kahn's algorithm over the first max_e edges, LIFO out-edge order
    task automatic model(input int max_e);
        int indeg[MAX_NODES];
        bit act[MAX_NODES];
        int q[$];
        int ne;
        int n;
        ne = (g_src.size() < max_e) ? g_src.size() : max_e;
        for (int i = 0; i < int'(MAX_NODES); i++) begin indeg[i] = 0; act[i] = 0; end
        for (int e = 0; e < ne; e++) begin
            act[g_src[e]] = 1;
            act[g_dst[e]] = 1;
            indeg[g_dst[e]]++;
        end
        exp_nc = 0;
        exp_q.delete();
        for (int i = 0; i < int'(MAX_NODES); i++) begin
            if (act[i]) exp_nc++;
            if (act[i] && indeg[i] == 0) q.push_back(i);
        end
        while (q.size() > 0) begin
            n = q.pop_front();
            exp_q.push_back(n);
            for (int e = ne - 1; e >= 0; e--) begin
                if (g_src[e] == n) begin
                    indeg[g_dst[e]]--;
                    if (indeg[g_dst[e]] == 0) q.push_back(g_dst[e]);
                end
            end
        end
        exp_cyc = (exp_q.size() != exp_nc) ? 1 : 0;
    endtask

    task automatic reset_check();
        chk("reset_outputs",
            int'({load_ready, out_valid, sort_done, cycle_detected, edge_overflow}), 0);
        chk("reset_node_count", int'(node_count), 0);
        chk("reset_sorted_node", int'(sorted_node), 0);
    endtask

    task automatic release_and_wait();
        int cnt;
        rst_n = 1'b1;
        cnt = 0;
        while (!load_ready && cnt < int'(MAX_NODES) + 50) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        chk("clear_len", cnt, int'(MAX_NODES));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        edge_valid = 1'b0; decoding_done = 1'b0; out_ready = 1'b0;
        s_edge_valid = 1'b0; s_decoding_done = 1'b0; s_out_ready = 1'b0;
        @(negedge clk);
        reset_check();
        release_and_wait();
    endtask

    task automatic load_edges();
        chk("load_ready_on_load", int'(load_ready), 1);
        if (g_src.size() == 0) begin
            decoding_done = 1'b1;
            @(negedge clk);
        end else begin
            for (int i = 0; i < g_src.size(); i++) begin
                edge_valid    = 1'b1;
                src_node      = NW'(g_src[i]);
                dst_node      = NW'(g_dst[i]);
                decoding_done = (i == g_src.size() - 1);
                @(negedge clk);
            end
        end
        edge_valid = 1'b0;
        decoding_done = 1'b0;
    endtask

    // mode 0: always ready, 1: toggling, 2: random
    task automatic collect(input int mode);
        int            cyc;
        bit            prev_stall;
        logic [NW-1:0] prev_node;
        got_q.delete();
        cyc = 0;
        prev_stall = 0;
        prev_node = '0;
        while (!sort_done && cyc < 20000) begin
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_node", int'(sorted_node), int'(prev_node));
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) got_q.push_back(int'(sorted_node));
            prev_stall = out_valid && !out_ready;
            prev_node  = sorted_node;
            @(negedge clk);
            cyc++;
        end
        chk("sort_done", int'(sort_done), 1);
        out_ready = 1'b0;
    endtask

    task automatic compare(input string tag, input int nc, input int cyc, input int ovf, input int ovf_exp);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_out%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_node_count"}, nc, exp_nc);
        chk({tag, "_cycle"}, cyc, exp_cyc);
        chk({tag, "_overflow"}, ovf, ovf_exp);
    endtask

    task automatic set_graph(input int n, input int s[6], input int d[6]);
        g_src.delete();
        g_dst.delete();
        for (int i = 0; i < n; i++) begin
            g_src.push_back(s[i]);
            g_dst.push_back(d[i]);
        end
    endtask

    initial begin
        int a, b, t, n, base, cyc;
        int s6[6];
        int d6[6];

        rst_n = 1'b0;
        edge_valid = 1'b0; decoding_done = 1'b0; out_ready = 1'b0;
        src_node = '0; dst_node = '0;
        s_edge_valid = 1'b0; s_decoding_done = 1'b0; s_out_ready = 1'b0;
        s_src_node = '0; s_dst_node = '0;

        tbl[0] = '{3, '{0,1,2,0,0,0}, '{1,2,3,0,0,0}, 4, '{0,1,2,3,0,0}, 4, 0}; // chain
        tbl[1] = '{3, '{1,2,0,0,0,0}, '{2,1,4,0,0,0}, 2, '{0,4,0,0,0,0}, 4, 1}; // cycle
        tbl[2] = '{5, '{0,0,0,1,2,0}, '{8,8,8,8,8,0}, 4, '{0,1,2,8,0,0}, 4, 0}; // fan-in
        tbl[3] = '{2, '{3,1,0,0,0,0}, '{3,2,0,0,0,0}, 2, '{1,2,0,0,0,0}, 3, 1}; // self-loop
        tbl[4] = '{3, '{4,4,6,0,0,0}, '{6,6,5,0,0,0}, 3, '{4,6,5,0,0,0}, 3, 0}; // duplicate
        tbl[5] = '{3, '{0,0,0,0,0,0}, '{3,1,2,0,0,0}, 4, '{0,2,1,3,0,0}, 4, 0}; // LIFO walk
        tbl[6] = '{0, '{0,0,0,0,0,0}, '{0,0,0,0,0,0}, 0, '{0,0,0,0,0,0}, 0, 0}; // empty

        repeat (3) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            set_graph(tbl[v].ne, tbl[v].src, tbl[v].dst);
            exp_q.delete();
            for (int i = 0; i < tbl[v].nout; i++) exp_q.push_back(tbl[v].outv[i]);
            exp_nc  = tbl[v].nc;
            exp_cyc = tbl[v].cyc;
            do_reset();
            load_edges();
            collect(0);
            compare($sformatf("tbl%0d", v), int'(node_count), int'(cycle_detected),
                    int'(edge_overflow), 0);
        end

        // Diamond with a stalling consumer
        s6 = '{5,5,7,9,0,0};
        d6 = '{7,9,3,3,0,0};
        set_graph(4, s6, d6);
        exp_q = '{5, 9, 7, 3};
        exp_nc = 4;
        exp_cyc = 0;
        do_reset();
        load_edges();
        collect(1);
        compare("diamond", int'(node_count), int'(cycle_detected), int'(edge_overflow), 0);

        // Reset while walking the first node's edges, then a fresh graph
        s6 = '{0,1,2,3,0,0};
        d6 = '{1,2,3,4,0,0};
        set_graph(4, s6, d6);
        do_reset();
        load_edges();
        cyc = 0;
        while (!out_valid && cyc < 5000) begin @(negedge clk); cyc++; end
        chk("walk_first_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset_check();
        release_and_wait();
        s6 = '{10,11,0,0,0,0};
        d6 = '{11,12,0,0,0,0};
        set_graph(2, s6, d6);
        model(MAX_EDGES);
        load_edges();
        collect(0);
        compare("after_reset", int'(node_count), int'(cycle_detected), int'(edge_overflow), 0);

        // Random graphs, mostly acyclic, random consumer back-pressure
        for (int r = 0; r < 6; r++) begin
            g_src.delete();
            g_dst.delete();
            n = $urandom_range(1, 24);
            base = $urandom_range(0, 900);
            for (int i = 0; i < n; i++) begin
                a = base + $urandom_range(0, 11) * 7;
                b = base + $urandom_range(0, 11) * 7;
                if ($urandom_range(0, 7) != 0 && a > b) begin t = a; a = b; b = t; end
                g_src.push_back(a);
                g_dst.push_back(b);
            end
            model(MAX_EDGES);
            do_reset();
            load_edges();
            collect(2);
            compare($sformatf("rand%0d", r), int'(node_count), int'(cycle_detected),
                    int'(edge_overflow), 0);
        end

        // Edge-table overflow on the 4-edge instance
        g_src.delete();
        g_dst.delete();
        for (int i = 0; i < 6; i++) begin g_src.push_back(i); g_dst.push_back(i + 1); end
        model(SE);
        do_reset();
        chk("small_load_ready", int'(s_load_ready), 1);
        for (int i = 0; i < 6; i++) begin
            s_edge_valid    = 1'b1;
            s_src_node      = SNW'(g_src[i]);
            s_dst_node      = SNW'(g_dst[i]);
            s_decoding_done = (i == 5);
            @(negedge clk);
        end
        s_edge_valid = 1'b0;
        s_decoding_done = 1'b0;
        s_out_ready = 1'b1;
        got_q.delete();
        cyc = 0;
        while (!s_sort_done && cyc < 2000) begin
            if (s_out_valid && s_out_ready) got_q.push_back(int'(s_sorted_node));
            @(negedge clk);
            cyc++;
        end
        chk("small_sort_done", int'(s_sort_done), 1);
        compare("overflow", int'(s_node_count), int'(s_cycle_detected),
                int'(s_edge_overflow), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
